// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract engine: FSM encodings
// and the counter-width helper.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Number of bits needed to count 0..value-1 (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand and result handshakes of the serial adder.
// The producer/consumer side uses the master modport, and the engine uses slave.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell. This is the only arithmetic element in the
// serial engine.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine. It feeds the operands LSB-first through one
// full_adder and keeps the carry in a flop between bits. Subtraction is done
// as A + ~B + 1: B is inverted at load and the carry is preset to 1.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // FSM and serial datapath: load on accept, one bit per SHIFT cycle, hold in DONE.
    // NOTE: every register here uses <= so all flops sample pre-edge values;
    // a blocking '=' would let the shifted a_sh/b_sh leak into the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.in_a;
                        b_sh  <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        carry <= bus.in_sub;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
                    carry  <= fa_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // The MSB overflows when its carry-in differs from its carry-out.
                        ovf   <= carry ^ fa_cout;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs are decoded directly from the state.
    // in_ready is also gated by rst_n, so it stays low while reset is asserted.
    assign bus.in_ready  = rst_n && (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state == ST_SHIFT);
    assign bus.out_sum   = res_sh;
    assign bus.out_cout  = carry;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8. It covers reset, add and
// subtract corner cases, stall, reset during SHIFT, and a back-to-back sweep
// against a reference model. Inputs change and outputs are sampled on the
// falling edge of clk.
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a handshake never completes.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: one wide add, with signed overflow taken from the operand signs.
    function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
        logic [7:0] bb;
        logic [8:0] full;
        logic       v;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
        v    = (a[7] == bb[7]) && (full[7] != a[7]);
        return {full[8], v, full[7:0]};
    endfunction

    // Present one operand pair for a single cycle. Returns half a cycle after the accept edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub);
        @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        check("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait for out_valid with a bounded budget, then check the latency, the busy duration and the result.
    task automatic wait_result(input string tag, input logic [7:0] sum, input logic cout, input logic ovf);
        int n;
        int busy_cnt;
        n        = 0;
        busy_cnt = 0;
        while (!bus.out_valid && n < 50) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 32'd8);
        check({tag, "_busy_cycles"}, busy_cnt, 32'd8);
        check({tag, "_sum"}, {24'd0, bus.out_sum}, {24'd0, sum});
        check({tag, "_cout"}, {31'd0, bus.out_cout}, {31'd0, cout});
        check({tag, "_ovf"}, {31'd0, bus.out_ovf}, {31'd0, ovf});
    endtask

    // Accept the result for one cycle, then confirm that the engine returned to IDLE.
    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        logic [9:0] exp_res;
        logic       pending;
        int         cyc;
        int         last_accept;
        int         accepts;
        int         ops_done;

        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_out_sum", {24'd0, bus.out_sum}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Basic add and the add boundaries.
        send(8'h35, 8'h4A, 1'b0);
        wait_result("add_35_4a", 8'h7F, 1'b0, 1'b0);
        drain("add_35_4a");
        send(8'hFF, 8'h01, 1'b0);
        wait_result("add_ff_01", 8'h00, 1'b1, 1'b0);
        drain("add_ff_01");
        send(8'h7F, 8'h01, 1'b0);
        wait_result("add_7f_01", 8'h80, 1'b0, 1'b1);
        drain("add_7f_01");

        // Subtract: borrow, and signed overflow.
        send(8'h10, 8'h20, 1'b1);
        wait_result("sub_10_20", 8'hF0, 1'b0, 1'b0);
        drain("sub_10_20");
        send(8'h80, 8'h01, 1'b1);
        wait_result("sub_80_01", 8'h7F, 1'b1, 1'b1);
        drain("sub_80_01");

        // Stall in DONE while in_valid and in_a toggle; the outputs must hold.
        send(8'h12, 8'h34, 1'b0);
        wait_result("stall_op", 8'h46, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.in_a     = bus.in_a ^ 8'hA5;
            @(negedge clk);
            check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall_out_sum", {24'd0, bus.out_sum}, 32'h46);
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        drain("stall_op");

        // Reset asserted while SHIFT has cnt=4.
        send(8'h55, 8'h22, 1'b0);
        repeat (4) @(negedge clk);
        check("mid_shift_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_outs", {22'd0, bus.out_cout, bus.out_ovf, bus.out_sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_idle_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (10) @(negedge clk);
        check("mid_rst_no_result", {31'd0, bus.out_valid}, 32'd0);
        send(8'h01, 8'h01, 1'b0);
        wait_result("after_rst", 8'h02, 1'b0, 1'b0);
        drain("after_rst");

        // Back-to-back sweep: in_valid and out_ready both held high, random operands.
        // Operands are rerandomised on every cycle that is not an accept.
        pending     = 1'b0;
        cyc         = 0;
        last_accept = 0;
        accepts     = 0;
        ops_done    = 0;
        ra          = 8'($urandom);
        rb          = 8'($urandom);
        rs          = 1'($urandom);
        exp_res     = '0;
        @(negedge clk);
        bus.in_a      = ra;
        bus.in_b      = rb;
        bus.in_sub    = rs;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (ops_done < 1000 && cyc < 20000) begin
            #1;
            if (bus.out_valid) begin
                check("sweep_pending", {31'd0, pending}, 32'd1);
                check("sweep_result", {22'd0, bus.out_cout, bus.out_ovf, bus.out_sum}, {22'd0, exp_res});
                pending = 1'b0;
                ops_done++;
            end
            if (bus.in_ready) begin
                if (accepts > 0) check("issue_interval", cyc - last_accept, 32'd10);
                last_accept = cyc;
                exp_res     = ref_op(ra, rb, rs);
                pending     = 1'b1;
                accepts++;
            end else begin
                ra         = 8'($urandom);
                rb         = 8'($urandom);
                rs         = 1'($urandom);
                bus.in_a   = ra;
                bus.in_b   = rb;
                bus.in_sub = rs;
            end
            @(negedge clk);
            cyc++;
        end
        check("sweep_complete", ops_done, 32'd1000);
        bus.in_valid = 1'b0;
        repeat (12) @(negedge clk);
        bus.out_ready = 1'b0;
        check("final_idle", {31'd0, bus.in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
